// File: rtl/barrel_shifter_pipe_pkg.sv
// barrel_pkg: operation codes and op-class helpers shared by the pipelined barrel shifter.
package barrel_pkg;
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic is_left(input logic [2:0] op);
        return op == OP_SLL || op == OP_ROL;
    endfunction

    function automatic logic is_rotate(input logic [2:0] op);
        return op == OP_ROL || op == OP_ROR;
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return op == OP_SRA;
    endfunction
endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// barrel_shifter_pipe_if: operand and result valid/ready channels of the barrel shifter.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_sh;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_sh, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_sh, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/barrel_shifter_pipe_level.sv
// barrel_level: one combinational shift level moving data by SHIFT and tracking the last bit out.
module barrel_level
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    input  logic [2:0]       op,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             co
);
    logic             act;
    logic             lft;
    logic [SHIFT-1:0] lfill;
    logic [SHIFT-1:0] rfill;

    // Codes above OP_ROR pass through untouched, so the running carry stays 0.
    always_comb begin
        act   = en && op <= OP_ROR;
        lft   = is_left(op);
        lfill = is_rotate(op) ? d[WIDTH-1 -: SHIFT] : '0;
        rfill = is_rotate(op) ? d[SHIFT-1:0] : is_arith(op) ? {SHIFT{d[WIDTH-1]}} : '0;
        q     = !act ? d : lft ? {d[WIDTH-SHIFT-1:0], lfill} : {rfill, d[WIDTH-1:SHIFT]};
        co    = !act ? c : lft ? d[WIDTH-SHIFT] : d[SHIFT-1];
    end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined barrel shifter, LEVELS_PER_STAGE shift levels per register stage,
// with a per-stage valid/ready handshake and registered result/carry outputs.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 3
) (
    input logic                  clk,
    input logic                  rst,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SHW     = $clog2(WIDTH);
    localparam int NSTAGES = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    logic [WIDTH-1:0] sd [NSTAGES];
    logic             sc [NSTAGES];
    logic [2:0]       so [NSTAGES];
    logic [SHW-1:0]   ss [NSTAGES];
    logic             vin [NSTAGES];
    logic [WIDTH-1:0] rd [NSTAGES];
    logic             rc [NSTAGES];
    logic [2:0]       rop [NSTAGES];
    logic [SHW-1:0]   rsh [NSTAGES];
    logic [NSTAGES-1:0] v;
    logic             rdy [NSTAGES+1];
    logic [WIDTH-1:0] lo_d [SHW];
    logic             lo_c [SHW];

    always_comb begin
        rdy[NSTAGES] = bus.out_ready;
        for (int i = NSTAGES - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
    end

    // Level k sees the registered operand of its own stage for op and shift amount.
    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int S = k / LEVELS_PER_STAGE;
        logic [WIDTH-1:0] xd;
        logic             xc;
        if (k % LEVELS_PER_STAGE == 0) begin : g_head
            assign xd = sd[S];
            assign xc = sc[S];
        end else begin : g_chain
            assign xd = lo_d[k-1];
            assign xc = lo_c[k-1];
        end
        barrel_level #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_lvl (
            .d(xd), .c(xc), .op(so[S]), .en(ss[S][k]), .q(lo_d[k]), .co(lo_c[k])
        );
    end

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stg
        localparam int E = ((s + 1) * LEVELS_PER_STAGE < SHW ? (s + 1) * LEVELS_PER_STAGE : SHW) - 1;
        logic             vr;
        logic [WIDTH-1:0] dr;
        logic             cr;
        logic [2:0]       opr;
        logic [SHW-1:0]   shr;
        if (s == 0) begin : g_src_in
            assign sd[s]  = bus.in_data;
            assign sc[s]  = 1'b0;
            assign so[s]  = bus.in_op;
            assign ss[s]  = bus.in_sh;
            assign vin[s] = bus.in_valid;
        end else begin : g_src_reg
            assign sd[s]  = rd[s-1];
            assign sc[s]  = rc[s-1];
            assign so[s]  = rop[s-1];
            assign ss[s]  = rsh[s-1];
            assign vin[s] = v[s-1];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vr  <= 1'b0;
                dr  <= '0;
                cr  <= 1'b0;
                opr <= '0;
                shr <= '0;
            end else begin
                if (rdy[s]) vr <= vin[s];
                if (vin[s] && rdy[s]) begin
                    dr  <= lo_d[E];
                    cr  <= lo_c[E];
                    opr <= so[s];
                    shr <= ss[s];
                end
            end
        end
        assign v[s]   = vr;
        assign rd[s]  = dr;
        assign rc[s]  = cr;
        assign rop[s] = opr;
        assign rsh[s] = shr;
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[NSTAGES-1];
    assign bus.out_data  = rd[NSTAGES-1];
    assign bus.out_carry = rc[NSTAGES-1];
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed vector table plus stream, stall and reset sequences
// on a 32-bit default shifter and a 64-bit one-level-per-stage shifter.
module tb_barrel_shifter_pipe;
    import barrel_pkg::*;

    typedef struct {
        bit          b;
        logic [2:0]  op;
        logic [63:0] d;
        int          sh;
        logic [63:0] q;
        logic        c;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   failed = 0;
    vec_t vt [19];
    vec_t st [4];

    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(32)) a_if ();
    barrel_shifter_pipe_if #(.WIDTH(64)) b_if ();

    barrel_shifter_pipe #(.WIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    barrel_shifter_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit b, input logic vld, input logic [2:0] op, input logic [63:0] d,
                         input int sh, input logic ordy);
        if (b) begin
            b_if.in_valid = vld; b_if.in_op = op; b_if.in_data = d;
            b_if.in_sh = 6'(sh); b_if.out_ready = ordy;
        end else begin
            a_if.in_valid = vld; a_if.in_op = op; a_if.in_data = d[31:0];
            a_if.in_sh = 5'(sh); a_if.out_ready = ordy;
        end
    endtask

    task automatic run_op(input vec_t t, input int idx);
        int   lat = 0;
        logic ov = 1'b0;
        @(negedge clk);
        drive(t.b, 1'b1, t.op, t.d, t.sh, 1'b1);
        #1;
        chk($sformatf("v%0d_in_ready", idx), t.b ? b_if.in_ready : a_if.in_ready, 1);
        while (!ov && lat < 20) begin
            @(negedge clk);
            drive(t.b, 1'b0, t.op, t.d, t.sh, 1'b1);
            #1;
            lat++;
            ov = t.b ? b_if.out_valid : a_if.out_valid;
        end
        chk($sformatf("v%0d_latency", idx), lat, t.lat);
        chk($sformatf("v%0d_data", idx), t.b ? b_if.out_data : {32'h0, a_if.out_data}, t.q);
        chk($sformatf("v%0d_carry", idx), t.b ? b_if.out_carry : a_if.out_carry, t.c);
    endtask

    function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
        return n == 0 ? x : (x << n) | (x >> (32 - n));
    endfunction

    initial begin
        vt[0]  = '{0, OP_SRA, 64'h80000010, 4,  64'hF8000001, 1'b0, 2};
        vt[1]  = '{0, OP_SLL, 64'h80000001, 1,  64'h00000002, 1'b1, 2};
        vt[2]  = '{0, OP_ROR, 64'h00000001, 1,  64'h80000000, 1'b1, 2};
        vt[3]  = '{0, OP_SLL, 64'hDEADBEEF, 0,  64'hDEADBEEF, 1'b0, 2};
        vt[4]  = '{0, OP_SRL, 64'hDEADBEEF, 0,  64'hDEADBEEF, 1'b0, 2};
        vt[5]  = '{0, OP_SRA, 64'hDEADBEEF, 0,  64'hDEADBEEF, 1'b0, 2};
        vt[6]  = '{0, OP_ROL, 64'hDEADBEEF, 0,  64'hDEADBEEF, 1'b0, 2};
        vt[7]  = '{0, OP_ROR, 64'hDEADBEEF, 0,  64'hDEADBEEF, 1'b0, 2};
        vt[8]  = '{0, 3'b110, 64'hDEADBEEF, 5,  64'hDEADBEEF, 1'b0, 2};
        vt[9]  = '{0, OP_SRL, 64'hDEADBEEF, 8,  64'h00DEADBE, 1'b1, 2};
        vt[10] = '{0, OP_ROL, 64'h12345678, 4,  64'h23456781, 1'b1, 2};
        vt[11] = '{0, OP_SLL, 64'h00000001, 31, 64'h80000000, 1'b0, 2};
        vt[12] = '{0, OP_SRA, 64'h7FFFFFFF, 31, 64'h00000000, 1'b1, 2};
        vt[13] = '{0, OP_SRA, 64'h80000000, 31, 64'hFFFFFFFF, 1'b0, 2};
        vt[14] = '{0, OP_ROL, 64'h80000000, 31, 64'h40000000, 1'b0, 2};
        vt[15] = '{0, OP_ROR, 64'hDEADBEEF, 16, 64'hBEEFDEAD, 1'b1, 2};
        vt[16] = '{1, OP_SRA, 64'h8000000000000010, 4,  64'hF800000000000001, 1'b0, 6};
        vt[17] = '{1, OP_SLL, 64'h8000000000000001, 1,  64'h0000000000000002, 1'b1, 6};
        vt[18] = '{1, OP_SRL, 64'h8000000000000000, 63, 64'h0000000000000001, 1'b0, 6};
        st[0]  = '{0, OP_SLL, 64'hA0000001, 1, 64'h40000002, 1'b1, 2};
        st[1]  = '{0, OP_SRL, 64'h00000003, 1, 64'h00000001, 1'b1, 2};
        st[2]  = '{0, OP_ROR, 64'h0000000F, 4, 64'hF0000000, 1'b1, 2};
        st[3]  = '{0, OP_SRA, 64'h80000000, 2, 64'hE0000000, 1'b0, 2};

        drive(0, 1'b0, OP_SLL, 64'h0, 0, 1'b1);
        drive(1, 1'b0, OP_SLL, 64'h0, 0, 1'b1);
        #2 rst = 1'b1;
        #2;
        chk("rst_a_out_valid", a_if.out_valid, 0);
        chk("rst_a_out_data", a_if.out_data, 0);
        chk("rst_a_out_carry", a_if.out_carry, 0);
        chk("rst_b_out_valid", b_if.out_valid, 0);
        chk("rst_b_out_data", b_if.out_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) run_op(vt[i], i);

        begin : stream
            int n = 0, first = -1, last = -1;
            logic [31:0] x = 32'h12345678;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                drive(0, c < 8, OP_ROL, {32'h0, x}, c < 8 ? c : 0, 1'b1);
                #1;
                if (a_if.out_valid) begin
                    if (first < 0) first = c;
                    last = c;
                    if (n < 8) begin
                        chk($sformatf("stream%0d_data", n), a_if.out_data, rol32(x, n));
                        chk($sformatf("stream%0d_carry", n), a_if.out_carry, n == 0 ? 1'b0 : x[32-n]);
                    end
                    n++;
                end
            end
            chk("stream_count", n, 8);
            chk("stream_first_cycle", first, 2);
            chk("stream_contiguous", last - first + 1, 8);
        end

        begin : stall
            int sent = 0, got = 0;
            bit holding = 0;
            logic [32:0] hold = '0;
            logic ordy;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                ordy = c >= 7;
                if (sent < 4) drive(0, 1'b1, st[sent].op, st[sent].d, st[sent].sh, ordy);
                else drive(0, 1'b0, OP_SLL, 64'h0, 0, ordy);
                #1;
                if (c == 6) begin
                    chk("stall_accepts", sent, 2);
                    chk("stall_in_ready", a_if.in_ready, 0);
                end
                if (holding && a_if.out_valid)
                    chk($sformatf("stall_stable_c%0d", c), {a_if.out_carry, a_if.out_data}, hold);
                holding = a_if.out_valid && !a_if.out_ready;
                hold = {a_if.out_carry, a_if.out_data};
                if (a_if.out_valid && a_if.out_ready) begin
                    if (got < 4) begin
                        chk($sformatf("stall%0d_data", got), a_if.out_data, st[got].q);
                        chk($sformatf("stall%0d_carry", got), a_if.out_carry, st[got].c);
                    end
                    got++;
                end
                if (a_if.in_valid && a_if.in_ready) sent++;
            end
            chk("stall_results", got, 4);
        end

        begin : mid_reset
            vec_t t = '{0, OP_ROR, 64'h00000001, 1, 64'h80000000, 1'b1, 2};
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                drive(0, 1'b1, OP_SLL, 64'h1, 3, 1'b0);
            end
            @(negedge clk);
            drive(0, 1'b0, OP_SLL, 64'h0, 0, 1'b0);
            #1;
            chk("pre_rst_out_valid", a_if.out_valid, 1);
            chk("pre_rst_out_data", a_if.out_data, 64'h8);
            rst = 1'b1;
            #1;
            chk("mid_rst_out_valid", a_if.out_valid, 0);
            chk("mid_rst_out_data", a_if.out_data, 0);
            chk("mid_rst_in_ready", a_if.in_ready, 1);
            @(negedge clk);
            rst = 1'b0;
            run_op(t, 100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
